// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: sizing constants shared by the FIFO read and write controllers.
package sync_fifo_pkg;
    localparam int FIFO_AW = 7;
    localparam int FIFO_DW = 32;
    typedef logic [1:0] occ_t;
endpackage

// File: rtl/sync_fifo_rd_obuf.sv
// sync_fifo_rd_obuf: 2-entry show-ahead output buffer; e0 is always the head word.
module sync_fifo_rd_obuf
    import sync_fifo_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] head_data,
    output occ_t          cnt
);
    logic [DW-1:0] e0, e1;
    logic          pop_v;
    occ_t          wr_idx;

    assign valid     = cnt != 2'd0;
    assign pop_v     = pop & valid;
    assign wr_idx    = cnt - occ_t'(pop_v);
    assign head_data = e0;

    // The shift on pop happens first so a same-cycle push lands behind the surviving word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            if (pop_v) e0 <= e1;
            if (push && wr_idx == 2'd0) e0 <= push_data;
            if (push && wr_idx != 2'd0) e1 <= push_data;
            cnt <= cnt + occ_t'(push) - occ_t'(pop_v);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) (push && !clr) |-> cnt != 2'd2);
endmodule

// File: rtl/sync_fifo_rdctrl.sv
// sync_fifo_rdctrl: FIFO read controller; issues memory reads against a 2-word credit
// and presents the data first-word-fall-through through a small output buffer.
module sync_fifo_rdctrl
    import sync_fifo_pkg::*;
#(
    parameter int AW = FIFO_AW,
    parameter int DW = FIFO_DW
) (
    input  logic          rclk_i,
    input  logic          rst_n,
    input  logic [AW-1:0] wpnt_i,
    input  logic [DW-1:0] rdata_i,
    input  logic          flush_i,
    input  logic          rready_i,
    output logic          ren_o,
    output logic [AW-1:0] raddr_o,
    output logic [AW-1:0] rpnt_o,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o,
    output logic          empty_o,
    output logic [AW-1:0] fill_o
);
    logic [AW-1:0] rpnt;
    logic          inflight, pop;
    occ_t          buf_cnt, occ;

    assign empty_o = rpnt == wpnt_i;
    assign fill_o  = wpnt_i - rpnt;
    assign pop     = rvalid_o & rready_i;
    assign occ     = buf_cnt + occ_t'(inflight);
    // Words in flight count against the buffer so a returning read always has a slot.
    assign ren_o   = ~empty_o & ~flush_i & ((occ - occ_t'(pop)) < 2'd2);
    assign raddr_o = rpnt;
    assign rpnt_o  = rpnt;

    always_ff @(posedge rclk_i or negedge rst_n) begin
        if (!rst_n) begin
            rpnt     <= '0;
            inflight <= 1'b0;
        end else if (flush_i) begin
            rpnt     <= wpnt_i;
            inflight <= 1'b0;
        end else begin
            if (ren_o) rpnt <= rpnt + 1'b1;
            inflight <= ren_o;
        end
    end

    sync_fifo_rd_obuf #(.DW(DW)) u_obuf (
        .clk       (rclk_i),
        .rst_n     (rst_n),
        .clr       (flush_i),
        .push      (inflight),
        .push_data (rdata_i),
        .pop       (pop),
        .valid     (rvalid_o),
        .head_data (rdata_o),
        .cnt       (buf_cnt)
    );
endmodule

// File: tb/tb_sync_fifo_rdctrl.sv
// tb_sync_fifo_rdctrl: scoreboard bench for the FIFO read controller with a 1-cycle memory model.
module tb_sync_fifo_rdctrl;
    localparam int AW = 3;
    localparam int DW = 8;

    logic          clk = 1'b0, rst_n = 1'b0, flush = 1'b0, rready = 1'b0;
    logic [AW-1:0] wpnt = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          ren, rvalid, empty;
    logic [AW-1:0] raddr, rpnt, fill, exp_p;
    logic [DW-1:0] rdata, exp_w;
    logic [DW-1:0] mem [8];
    logic [DW-1:0] exp_q [$];
    int            checks = 0, errors = 0;

    sync_fifo_rdctrl #(.AW(AW), .DW(DW)) dut (
        .rclk_i   (clk),
        .rst_n    (rst_n),
        .wpnt_i   (wpnt),
        .rdata_i  (mem_rdata),
        .flush_i  (flush),
        .rready_i (rready),
        .ren_o    (ren),
        .raddr_o  (raddr),
        .rpnt_o   (rpnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .empty_o  (empty),
        .fill_o   (fill)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ren) mem_rdata <= mem[raddr];

    // Scoreboard: every accepted word must be the oldest outstanding expected word.
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got %h expected none", rdata);
            end else begin
                exp_w = exp_q.pop_front();
                if (rdata !== exp_w) begin
                    errors++;
                    $display("FAIL pop_data got %h expected %h", rdata, exp_w);
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next();
        rst_n = 1'b0;
        wpnt = '0;
        flush = 1'b0;
        rready = 1'b0;
        exp_q.delete();
        next();
        next();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wpnt = '0;
        repeat (2) next();
        checks++;
        if ({rpnt, raddr, ren, rvalid, rdata, empty, fill} !== {3'd0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_hold got %b expected %b", {rpnt, raddr, ren, rvalid, rdata, empty, fill},
                     {3'd0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd0});
        end
        rst_n = 1'b1;
        next();
        checks++;
        if ({rpnt, ren, rvalid, rdata, empty, fill} !== {3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL reset_release got %b expected %b", {rpnt, ren, rvalid, rdata, empty, fill},
                     {3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd0});
        end
    endtask

    task automatic test_latency();
        next();
        mem[0] = 8'hA5;
        wpnt = 3'd1;
        exp_q.push_back(8'hA5);
        #1;
        checks++;
        if ({ren, raddr, rpnt} !== {1'b1, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL lat_issue got ren=%b raddr=%0d rpnt=%0d expected 1 0 0", ren, raddr, rpnt);
        end
        next();
        checks++;
        if ({rpnt, ren, rvalid} !== {3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL lat_t1 got rpnt=%0d ren=%b rvalid=%b expected 1 0 0", rpnt, ren, rvalid);
        end
        next();
        checks++;
        if ({rvalid, rdata} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL lat_t2 got rvalid=%b rdata=%h expected 1 a5", rvalid, rdata);
        end
        rready = 1'b1;
        next();
        rready = 1'b0;
        checks++;
        if (rvalid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL lat_after got rvalid=%b pending=%0d expected 0 0", rvalid, exp_q.size());
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem[i] = DW'(i + 1);
            exp_q.push_back(DW'(i + 1));
        end
        rready = 1'b1;
        wpnt = 3'd5;
        for (int c = 1; c <= 7; c++) begin
            next();
            if (c >= 2 && c <= 6) begin
                checks++;
                if (rvalid !== 1'b1 || rdata !== DW'(c - 1)) begin
                    errors++;
                    $display("FAIL stream_c%0d got rvalid=%b rdata=%h expected 1 %h", c, rvalid, rdata, DW'(c - 1));
                end
            end
        end
        checks++;
        if (rvalid !== 1'b0 || empty !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_end got rvalid=%b empty=%b pending=%0d expected 0 1 0", rvalid, empty, exp_q.size());
        end
        rready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            mem[i] = DW'(i + 1);
            exp_q.push_back(DW'(i + 1));
        end
        wpnt = 3'd5;
        repeat (5) next();
        checks++;
        if ({rpnt, fill, ren, rvalid, rdata} !== {3'd2, 3'd3, 1'b0, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL bp_hold got rpnt=%0d fill=%0d ren=%b rvalid=%b rdata=%h expected 2 3 0 1 01",
                     rpnt, fill, ren, rvalid, rdata);
        end
        rready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) next();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain got pending=%0d expected 0", exp_q.size());
        end
        next();
        checks++;
        if (rvalid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL bp_end got rvalid=%b empty=%b expected 0 1", rvalid, empty);
        end
        rready = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        wpnt = 3'd6;
        flush = 1'b1;
        next();
        flush = 1'b0;
        checks++;
        if ({rpnt, empty, rvalid} !== {3'd6, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_start got rpnt=%0d empty=%b rvalid=%b expected 6 1 0", rpnt, empty, rvalid);
        end
        mem[6] = 8'h66;
        mem[7] = 8'h77;
        mem[0] = 8'h88;
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h88);
        rready = 1'b1;
        wpnt = 3'd1;
        #1;
        checks++;
        if ({fill, rpnt, ren} !== {3'd3, 3'd6, 1'b1}) begin
            errors++;
            $display("FAIL wrap_fill got fill=%0d rpnt=%0d ren=%b expected 3 6 1", fill, rpnt, ren);
        end
        for (int k = 1; k <= 3; k++) begin
            next();
            exp_p = 3'd6 + AW'(k);
            checks++;
            if (rpnt !== exp_p) begin
                errors++;
                $display("FAIL wrap_rpnt%0d got %0d expected %0d", k, rpnt, exp_p);
            end
        end
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) next();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_drain got pending=%0d expected 0", exp_q.size());
        end
        rready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) mem[i] = DW'(8'hF0 + i);
        wpnt = 3'd4;
        next();
        flush = 1'b1;
        #1;
        checks++;
        if (ren !== 1'b0) begin
            errors++;
            $display("FAIL flush_ren got %b expected 0", ren);
        end
        next();
        flush = 1'b0;
        checks++;
        if ({rvalid, rpnt, empty, fill} !== {1'b0, 3'd4, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL flush_after got rvalid=%b rpnt=%0d empty=%b fill=%0d expected 0 4 1 0",
                     rvalid, rpnt, empty, fill);
        end
        rready = 1'b1;
        repeat (4) next();
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_ghost got rvalid=%b rdata=%h expected 0", rvalid, rdata);
        end
        rready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 5; i++) mem[i] = DW'(8'h11 * (i + 1));
        rready = 1'b1;
        wpnt = 3'd5;
        next();
        next();
        rst_n = 1'b0;
        wpnt = '0;
        exp_q.delete();
        #1;
        checks++;
        if ({rpnt, raddr, ren, rvalid, rdata, empty, fill} !== {3'd0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL async_reset got %b expected %b", {rpnt, raddr, ren, rvalid, rdata, empty, fill},
                     {3'd0, 3'd0, 1'b0, 1'b0, 8'd0, 1'b1, 3'd0});
        end
        next();
        rst_n = 1'b1;
        repeat (4) next();
        checks++;
        if ({rvalid, rpnt} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL async_after got rvalid=%b rpnt=%0d expected 0 0", rvalid, rpnt);
        end
        rready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        test_reset();
        test_latency();
        test_stream();
        test_backpressure();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_rdctrl.md
Name: sync_fifo_rdctrl

Overview:
Read-side controller of the synchronous FIFO, directly downstream of the write controller. It consumes the write pointer, decides when the memory holds unread data, and issues synchronous memory reads. It returns the read pointer to the write controller for the full compare. Read data goes into a 2-entry show-ahead output buffer with a valid/ready handshake, so the consumer sees first-word-fall-through at one word per cycle.

Parameters:
AW, 7, pointer/address width; memory has 2^AW slots, 2^AW-1 usable (one slot is left empty so full and empty can be told apart)
DW, 32, data width

Ports:
rclk_i  in  1  read clock, same clock net as the write side
rst_n  in  1  asynchronous active-low reset
wpnt_i  in  AW  write pointer from the write controller (next slot to write)
rdata_i  in  DW  memory read data, valid 1 cycle after ren_o
flush_i  in  1  synchronous flush: discards all unread data
rready_i  in  1  consumer accepts rdata_o
ren_o  out  1  memory read enable
raddr_o  out  AW  memory read address; always equals rpnt_o
rpnt_o  out  AW  read pointer, returned to the write controller's rpnt_i
rvalid_o  out  1  rdata_o is valid
rdata_o  out  DW  head word of the output buffer
empty_o  out  1  memory holds no unread words: rpnt_o == wpnt_i (combinational)
fill_o  out  AW  memory occupancy: (wpnt_i - rpnt_o) mod 2^AW; excludes words already in the buffer or in flight

Behaviour:
- Reset (asynchronous, rst_n=0): rpnt_o=0, raddr_o=0, ren_o=0, rvalid_o=0, rdata_o=0, in-flight flag=0, buffer count=0, empty_o=1 when wpnt_i=0. Reset can occur mid-stream; a read in flight is dropped.
- pop = rvalid_o & rready_i. occ = buf_cnt + inflight, ranging 0..2.
- Read issue: ren_o = ~empty_o & ~flush_i & ((occ - pop) < 2). This is combinational. In the issue cycle raddr_o = rpnt_o; at the next edge rpnt_o increments by 1 and wraps from 2^AW-1 to 0 by natural AW-bit overflow.
- The slot is freed toward the write side at the same edge on which the memory samples the address. This is safe because the earliest write to that slot is the following edge.
- inflight <= ren_o. When inflight=1, rdata_i is written into the buffer at the next edge.
- Buffer: 2-entry FIFO. Head goes to rdata_o; rvalid_o = (buf_cnt != 0). Push and pop in the same cycle keep the count unchanged and preserve order. A push when the buffer is already full cannot happen; the credit rule prevents it (add an assertion).
- Latency: wpnt_i advances in cycle t on an empty, idle block -> ren_o=1 in cycle t -> rvalid_o=1 in cycle t+2.
- Throughput with rready_i held 1: one word per cycle, no bubbles.
- Backpressure (rready_i=0): at most 2 words are pulled from memory; ren_o then stays 0; rdata_o and rvalid_o stay stable until accepted.
- Empty with rready_i=1: rvalid_o=0; rready_i is ignored and nothing is popped.
- Flush (flush_i=1 at edge e): after e, rpnt_o = wpnt_i as sampled at e, buf_cnt=0, inflight=0 (in-flight data discarded), rvalid_o=0. ren_o=0 during the flush cycle. A pop in the flush cycle is still a valid transfer. Flush has priority over issue and push.
- Simultaneous write and read of the same slot cannot occur: empty_o gates reads, and the write controller's full compare gates writes.

Decomposition:
- Package sync_fifo_pkg holds the AW/DW default constants shared with the write controller, and a typedef for the 2-bit occupancy count.
- Sub-module sync_fifo_rd_obuf implements the 2-entry show-ahead buffer. Ports: clk, rst_n, clr, push, push_data, pop, valid, head_data, cnt.
- The top level holds the pointer, in-flight flag, credit logic and flush.

Test Plan (AW=3, DW=8, memory model with 1-cycle read latency):
1. Assert and release reset with wpnt_i=0 -> rpnt_o=0, ren_o=0, rvalid_o=0, rdata_o=0, empty_o=1, fill_o=0.
2. Preload mem[0]=0xA5, set wpnt_i 0->1 at cycle t -> ren_o=1 and raddr_o=0 at t; rpnt_o=1 at t+1; rvalid_o=1 with rdata_o=0xA5 at t+2.
3. Preload mem[0..4]=0x01..0x05, wpnt_i=5, rready_i=1 -> rvalid_o high 5 consecutive cycles carrying 0x01..0x05; then empty_o=1 and rvalid_o=0.
4. Same preload, rready_i=0 -> exactly 2 reads issued; rpnt_o=2, fill_o=3; rdata_o stays 0x01. Raise rready_i -> 0x01..0x05 delivered in order, no loss or duplicates.
5. Wrap: rpnt_o=6, wpnt_i=1, mem[6]=0x66, mem[7]=0x77, mem[0]=0x88, rready_i=1 -> outputs 0x66, 0x77, 0x88; rpnt_o sequence 6, 7, 0, 1; fill_o=3 before the first issue.
6. Flush with ren_o=1 and a read in flight, wpnt_i=4 -> next cycle rvalid_o=0 and rpnt_o=4; the in-flight word never appears. Mid-stream async reset likewise gives every output its reset value immediately.
